// File: rtl/axi_lite_mem_slave_if.sv
// AXI-lite bundle between the 1x1 interconnect s2m side and the memory slave.
// Signal names match the interconnect's s2m_* ports one-for-one.
interface axi_lite_mem_slave_if;
  logic [63:0] s2m_aw_addr;
  logic        s2m_aw_valid;
  logic [3:0]  s2m_aw_id;
  logic [2:0]  s2m_aw_prot;
  logic        s2m_aw_ready;
  logic [63:0] s2m_wdata;
  logic        s2m_wvalid;
  logic [8:0]  s2m_wstrb;
  logic        s2m_wready;
  logic        s2m_bvalid;
  logic [3:0]  s2m_bid;
  logic [1:0]  s2m_bresp;
  logic        s2m_bready;
  logic [63:0] s2m_ar_addr;
  logic        s2m_ar_valid;
  logic [3:0]  s2m_ar_id;
  logic [2:0]  s2m_ar_prot;
  logic        s2m_ar_ready;
  logic [63:0] s2m_rdata;
  logic        s2m_rvalid;
  logic [3:0]  s2m_rid;
  logic [1:0]  s2m_rrsesp;
  logic        s2m_rready;

  modport master (
    output s2m_aw_addr, s2m_aw_valid, s2m_aw_id, s2m_aw_prot,
    input  s2m_aw_ready,
    output s2m_wdata, s2m_wvalid, s2m_wstrb,
    input  s2m_wready,
    input  s2m_bvalid, s2m_bid, s2m_bresp,
    output s2m_bready,
    output s2m_ar_addr, s2m_ar_valid, s2m_ar_id, s2m_ar_prot,
    input  s2m_ar_ready,
    input  s2m_rdata, s2m_rvalid, s2m_rid, s2m_rrsesp,
    output s2m_rready
  );

  modport slave (
    input  s2m_aw_addr, s2m_aw_valid, s2m_aw_id, s2m_aw_prot,
    output s2m_aw_ready,
    input  s2m_wdata, s2m_wvalid, s2m_wstrb,
    output s2m_wready,
    output s2m_bvalid, s2m_bid, s2m_bresp,
    input  s2m_bready,
    input  s2m_ar_addr, s2m_ar_valid, s2m_ar_id, s2m_ar_prot,
    output s2m_ar_ready,
    output s2m_rdata, s2m_rvalid, s2m_rid, s2m_rrsesp,
    input  s2m_rready
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI-lite memory slave: DEPTH x 64-bit register memory, byte strobes,
// SLVERR on out-of-range addresses, independent read and write paths.
module axi_lite_mem_slave #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic aclk,
  input logic arst,
  axi_lite_mem_slave_if.slave bus
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [DEPTH-1:0][63:0] mem;

  logic             aw_held;
  logic             aw_ok;
  logic [IDX_W-1:0] aw_idx;
  logic [3:0]       aw_id;
  logic             w_held;
  logic [63:0]      w_data;
  logic [7:0]       w_strb;

  logic        b_valid;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        r_valid;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic [63:0] r_data;

  logic             aw_hs, w_hs, ar_hs;
  logic             b_hs, r_hs, commit;
  logic             ar_ok;
  logic [IDX_W-1:0] ar_idx;
  logic [63:0]      w_mask;
  logic [63:0]      w_word;
  logic             unused_bits;

  assign aw_hs  = bus.s2m_aw_valid && bus.s2m_aw_ready;
  assign w_hs   = bus.s2m_wvalid && bus.s2m_wready;
  assign ar_hs  = bus.s2m_ar_valid && bus.s2m_ar_ready;
  assign b_hs   = b_valid && bus.s2m_bready;
  assign r_hs   = r_valid && bus.s2m_rready;
  assign commit = aw_held && w_held
               && (!b_valid || bus.s2m_bready);

  assign ar_idx = bus.s2m_ar_addr[IDX_W+2:3];
  assign ar_ok  = bus.s2m_ar_addr[63:IDX_W+3] == '0;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < 8; b++)
      w_mask[8*b +: 8] = {8{w_strb[b]}};
  end

  assign w_word = (mem[aw_idx] & ~w_mask)
                | (w_data & w_mask);

  // Everything the master can see is forced low while reset is held.
  assign bus.s2m_aw_ready = !arst && !aw_held;
  assign bus.s2m_wready   = !arst && !w_held;
  assign bus.s2m_ar_ready = !arst
                         && (!r_valid || bus.s2m_rready);
  assign bus.s2m_bvalid   = !arst && b_valid;
  assign bus.s2m_bid      = arst ? '0 : b_id;
  assign bus.s2m_bresp    = arst ? '0 : b_resp;
  assign bus.s2m_rvalid   = !arst && r_valid;
  assign bus.s2m_rid      = arst ? '0 : r_id;
  assign bus.s2m_rrsesp   = arst ? '0 : r_resp;
  assign bus.s2m_rdata    = arst ? '0 : r_data;

  assign unused_bits = ^{bus.s2m_aw_addr[2:0],
                         bus.s2m_ar_addr[2:0],
                         bus.s2m_aw_prot,
                         bus.s2m_ar_prot,
                         bus.s2m_wstrb[8]};

  always_ff @(posedge aclk) begin
    if (arst) begin
      aw_held <= 1'b0;
      aw_ok   <= 1'b0;
      aw_idx  <= '0;
      aw_id   <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      b_valid <= 1'b0;
      b_id    <= '0;
      b_resp  <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_resp  <= '0;
      r_data  <= '0;
      mem     <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= bus.s2m_aw_addr[IDX_W+2:3];
        aw_ok   <= bus.s2m_aw_addr[63:IDX_W+3] == '0;
        aw_id   <= bus.s2m_aw_id;
      end else if (commit) begin
        aw_held <= 1'b0;
      end

      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= bus.s2m_wdata;
        w_strb <= bus.s2m_wstrb[7:0];
      end else if (commit) begin
        w_held <= 1'b0;
      end

      // A commit on the B handshake edge reloads the response slot.
      if (commit) begin
        b_valid <= 1'b1;
        b_id    <= aw_id;
        b_resp  <= aw_ok ? OKAY : SLVERR;
      end else if (b_hs) begin
        b_valid <= 1'b0;
      end

      if (commit && aw_ok)
        mem[aw_idx] <= w_word;

      // Reads sample mem before any same-edge commit lands.
      if (ar_hs) begin
        r_valid <= 1'b1;
        r_id    <= bus.s2m_ar_id;
        r_resp  <= ar_ok ? OKAY : SLVERR;
        r_data  <= ar_ok ? mem[ar_idx] : '0;
      end else if (r_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: directed cases plus randomized
// traffic checked against a word-array reference model.
module tb_axi_lite_mem_slave;
  localparam int DEPTH = 16;

  logic aclk = 1'b0;
  logic arst = 1'b1;
  always #5 aclk = ~aclk;

  axi_lite_mem_slave_if bus();

  axi_lite_mem_slave #(.DEPTH(DEPTH)) dut (
    .aclk(aclk),
    .arst(arst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [63:0] data;
  } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [63:0] mm [DEPTH];

  int n_pass = 0;
  int n_total = 0;
  int b_issued = 0;
  int b_seen = 0;
  int r_issued = 0;
  int r_seen = 0;

  bit   rnd_mode = 1'b0;
  logic bready_dir = 1'b1;
  logic rready_dir = 1'b1;
  logic rb = 1'b1;
  logic rr = 1'b1;

  assign bus.s2m_bready = rnd_mode ? rb : bready_dir;
  assign bus.s2m_rready = rnd_mode ? rr : rready_dir;

  initial forever begin
    @(posedge aclk);
    #1;
    rb = ($urandom % 4) != 0;
    rr = ($urandom % 2) != 0;
  end

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h",
                  name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: got no handshake, required one", name);
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return (a >> 3) < 64'(DEPTH);
  endfunction

  function automatic logic [63:0] model_rd(input logic [63:0] a);
    if (!in_range(a)) return 64'd0;
    return mm[int'(a >> 3)];
  endfunction

  task automatic model_wr(input logic [63:0] a,
                          input logic [63:0] d,
                          input logic [8:0] s);
    logic [63:0] w;
    if (!in_range(a)) return;
    w = mm[int'(a >> 3)];
    for (int b = 0; b < 8; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mm[int'(a >> 3)] = w;
  endtask

  task automatic aw_send(input logic [63:0] a,
                         input logic [3:0] id, input int dly);
    int k = 0;
    repeat (dly) begin @(posedge aclk); #1; end
    bus.s2m_aw_addr  = a;
    bus.s2m_aw_id    = id;
    bus.s2m_aw_valid = 1'b1;
    forever begin
      @(negedge aclk);
      if (bus.s2m_aw_ready) break;
      k++;
      if (k > 300) break;
    end
    if (k > 300) timeout("aw_handshake");
    @(posedge aclk);
    #1;
    bus.s2m_aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d,
                        input logic [8:0] s, input int dly);
    int k = 0;
    repeat (dly) begin @(posedge aclk); #1; end
    bus.s2m_wdata  = d;
    bus.s2m_wstrb  = s;
    bus.s2m_wvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (bus.s2m_wready) break;
      k++;
      if (k > 300) break;
    end
    if (k > 300) timeout("w_handshake");
    @(posedge aclk);
    #1;
    bus.s2m_wvalid = 1'b0;
  endtask

  task automatic push_b(input logic [63:0] a, input logic [3:0] id);
    b_exp_t e;
    e.id   = id;
    e.resp = in_range(a) ? 2'b00 : 2'b10;
    b_q.push_back(e);
    b_issued++;
  endtask

  task automatic send_write(input logic [63:0] a,
                            input logic [63:0] d,
                            input logic [8:0] s,
                            input logic [3:0] id,
                            input int da, input int dw);
    push_b(a, id);
    model_wr(a, d, s);
    fork
      aw_send(a, id, da);
      w_send(d, s, dw);
    join
  endtask

  task automatic ar_issue(input logic [63:0] a,
                          input logic [3:0] id,
                          input r_exp_t e);
    int k = 0;
    r_q.push_back(e);
    r_issued++;
    bus.s2m_ar_addr  = a;
    bus.s2m_ar_id    = id;
    bus.s2m_ar_valid = 1'b1;
    forever begin
      @(negedge aclk);
      if (bus.s2m_ar_ready) break;
      k++;
      if (k > 300) break;
    end
    if (k > 300) timeout("ar_handshake");
    @(posedge aclk);
    #1;
    bus.s2m_ar_valid = 1'b0;
  endtask

  task automatic send_read(input logic [63:0] a, input logic [3:0] id);
    r_exp_t e;
    e.id   = id;
    e.resp = in_range(a) ? 2'b00 : 2'b10;
    e.data = model_rd(a);
    ar_issue(a, id, e);
  endtask

  task automatic wait_b();
    int k = 0;
    while (b_seen != b_issued && k < 500) begin
      @(negedge aclk);
      k++;
    end
    if (b_seen != b_issued) timeout("b_drain");
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_r();
    int k = 0;
    while (r_seen != r_issued && k < 500) begin
      @(negedge aclk);
      k++;
    end
    if (r_seen != r_issued) timeout("r_drain");
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = (64'($urandom % (DEPTH + 4)) << 3) | 64'($urandom % 8);
    if ($urandom % 8 == 0) a[40] = 1'b1;
    return a;
  endfunction

  logic        r_stall = 1'b0;
  logic [69:0] r_prev = '0;

  always @(negedge aclk) begin : monitor
    b_exp_t be;
    r_exp_t re;
    if (r_stall)
      check("r_hold",
            {bus.s2m_rvalid, bus.s2m_rid, bus.s2m_rrsesp, bus.s2m_rdata},
            {1'b1, r_prev});
    r_stall = bus.s2m_rvalid && !bus.s2m_rready;
    r_prev  = {bus.s2m_rid, bus.s2m_rrsesp, bus.s2m_rdata};
    if (bus.s2m_bvalid && bus.s2m_bready) begin
      b_seen++;
      if (b_q.size() == 0) begin
        n_total++;
        $display("FAIL b_extra: got bid %0d, required no B",
                 bus.s2m_bid);
      end else begin
        be = b_q.pop_front();
        check("bid", bus.s2m_bid, be.id);
        check("bresp", bus.s2m_bresp, be.resp);
      end
    end
    if (bus.s2m_rvalid && bus.s2m_rready) begin
      r_seen++;
      if (r_q.size() == 0) begin
        n_total++;
        $display("FAIL r_extra: got rid %0d, required no R",
                 bus.s2m_rid);
      end else begin
        re = r_q.pop_front();
        check("rid", bus.s2m_rid, re.id);
        check("rresp", bus.s2m_rrsesp, re.resp);
        check("rdata", bus.s2m_rdata, re.data);
      end
    end
  end

  initial begin : stim
    logic [63:0] old;
    r_exp_t e;
    bus.s2m_aw_addr  = '0;
    bus.s2m_aw_valid = 1'b0;
    bus.s2m_aw_id    = '0;
    bus.s2m_aw_prot  = '0;
    bus.s2m_wdata    = '0;
    bus.s2m_wvalid   = 1'b0;
    bus.s2m_wstrb    = '0;
    bus.s2m_ar_addr  = '0;
    bus.s2m_ar_valid = 1'b0;
    bus.s2m_ar_id    = '0;
    bus.s2m_ar_prot  = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;

    // Reset and post-reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_aw_ready", bus.s2m_aw_ready, 0);
    check("rst_w_ready", bus.s2m_wready, 0);
    check("rst_ar_ready", bus.s2m_ar_ready, 0);
    @(posedge aclk);
    #1 arst = 1'b0;
    @(negedge aclk);
    check("init_aw_ready", bus.s2m_aw_ready, 1);
    check("init_w_ready", bus.s2m_wready, 1);
    check("init_ar_ready", bus.s2m_ar_ready, 1);
    check("init_valids", {bus.s2m_bvalid, bus.s2m_rvalid}, 0);
    check("init_ids", {bus.s2m_bid, bus.s2m_rid,
                       bus.s2m_bresp, bus.s2m_rrsesp}, 0);
    check("init_rdata", bus.s2m_rdata, 0);
    @(posedge aclk);
    #1;

    // Basic write, AW and W on the same edge
    push_b(64'h18, 4'd3);
    model_wr(64'h18, 64'h1122334455667788, 9'h0FF);
    bus.s2m_aw_addr  = 64'h18;
    bus.s2m_aw_id    = 4'd3;
    bus.s2m_aw_valid = 1'b1;
    bus.s2m_wdata    = 64'h1122334455667788;
    bus.s2m_wstrb    = 9'h0FF;
    bus.s2m_wvalid   = 1'b1;
    @(posedge aclk);
    #1;
    bus.s2m_aw_valid = 1'b0;
    bus.s2m_wvalid   = 1'b0;
    @(negedge aclk);
    check("b_early", bus.s2m_bvalid, 0);
    check("aw_ready_held", bus.s2m_aw_ready, 0);
    @(negedge aclk);
    check("b_latency", bus.s2m_bvalid, 1);
    @(posedge aclk);
    #1;
    send_read(64'h18, 4'd5);
    @(negedge aclk);
    check("r_latency", bus.s2m_rvalid, 1);
    @(posedge aclk);
    #1;
    wait_r();

    // Partial strobe, bit 8 ignored
    send_write(64'h18, 64'hAAAAAAAAAAAAAAAA, 9'h10F, 4'd6, 0, 0);
    wait_b();
    send_read(64'h18, 4'd7);
    wait_r();

    // W well ahead of AW
    push_b(64'h8, 4'd9);
    model_wr(64'h8, 64'h0123456789ABCDEF, 9'h0FF);
    bus.s2m_wdata  = 64'h0123456789ABCDEF;
    bus.s2m_wstrb  = 9'h0FF;
    bus.s2m_wvalid = 1'b1;
    @(posedge aclk);
    #1 bus.s2m_wvalid = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      check("w_ready_held", bus.s2m_wready, 0);
      check("b_none_w_only", bus.s2m_bvalid, 0);
      @(posedge aclk);
      #1;
    end
    bus.s2m_aw_addr  = 64'h8;
    bus.s2m_aw_id    = 4'd9;
    bus.s2m_aw_valid = 1'b1;
    @(negedge aclk);
    check("w_ready_held", bus.s2m_wready, 0);
    @(posedge aclk);
    #1 bus.s2m_aw_valid = 1'b0;
    @(negedge aclk);
    check("b_decoupled_early", bus.s2m_bvalid, 0);
    @(negedge aclk);
    check("b_decoupled", bus.s2m_bvalid, 1);
    @(posedge aclk);
    #1;
    wait_b();
    send_read(64'h8, 4'd2);
    wait_r();

    // Out of range
    send_write(64'h80, 64'hDEADBEEFCAFEF00D, 9'h0FF, 4'd4, 0, 0);
    wait_b();
    send_read(64'h80, 4'd1);
    send_read(64'h0, 4'd2);
    wait_r();

    // B backpressure
    bready_dir = 1'b0;
    send_write(64'h20, 64'h1111, 9'h0FF, 4'd1, 0, 1);
    @(posedge aclk);
    #1;
    send_write(64'h28, 64'h2222, 9'h0FF, 4'd2, 1, 0);
    repeat (3) begin
      @(negedge aclk);
      check("bp_aw_ready", bus.s2m_aw_ready, 0);
      check("bp_w_ready", bus.s2m_wready, 0);
      check("bp_first_b", {bus.s2m_bvalid, bus.s2m_bid}, {1'b1, 4'd1});
      @(posedge aclk);
      #1;
    end
    bready_dir = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("bp_second_b", {bus.s2m_bvalid, bus.s2m_bid}, {1'b1, 4'd2});
    @(posedge aclk);
    #1;
    wait_b();

    // Back-to-back reads with rready toggling
    rnd_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send_read(64'(8 * (3 + i % 3)), 4'(i));
    wait_r();
    rnd_mode = 1'b0;

    // Read on the same edge as a commit to the same word
    send_write(64'h10, 64'h5, 9'h0FF, 4'd1, 0, 0);
    wait_b();
    old = model_rd(64'h10);
    send_write(64'h10, 64'h9, 9'h0FF, 4'd2, 0, 0);
    e.id   = 4'd3;
    e.resp = 2'b00;
    e.data = old;
    ar_issue(64'h10, 4'd3, e);
    wait_b();
    wait_r();
    send_read(64'h10, 4'd4);
    wait_r();

    // Reset with a held AW
    aw_send(64'h10, 4'd7, 0);
    arst = 1'b1;
    @(negedge aclk);
    check("rst_mid_aw_ready", bus.s2m_aw_ready, 0);
    check("rst_mid_bvalid", bus.s2m_bvalid, 0);
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1 arst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    repeat (3) begin
      @(negedge aclk);
      check("rst_no_b", bus.s2m_bvalid, 0);
      check("rst_aw_free", bus.s2m_aw_ready, 1);
    end
    @(posedge aclk);
    #1;
    send_read(64'h10, 4'd5);
    send_read(64'h18, 4'd6);
    wait_r();

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom % 2 == 0) begin
        send_write(rand_addr(), {$urandom, $urandom},
                   9'($urandom), 4'($urandom),
                   int'($urandom % 3), int'($urandom % 3));
        wait_b();
      end else begin
        repeat (1 + $urandom % 4)
          send_read(rand_addr(), 4'($urandom));
        wait_r();
      end
    end
    rnd_mode = 1'b0;
    repeat (4) @(posedge aclk);
    #1;

    check("b_queue_empty", b_q.size(), 0);
    check("r_queue_empty", r_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI-lite slave endpoint with a register-backed memory of DEPTH 64-bit words. It sits directly downstream of the 1x1 AXI-lite interconnect and connects port-for-port to its s2m_* side. It consumes AW/W/AR, returns B/R, applies byte strobes and flags out-of-range accesses with SLVERR. It is the default target for interconnect bring-up and regression.

## Interface
- DEPTH, 16: number of 64-bit words; power of two, 2..256.
- IDX_W, $clog2(DEPTH): word-index width, derived; do not override.
- aclk  input  1  clock; all logic on the rising edge.
- arst  input  1  reset, synchronous, active-high.
- s2m_aw_addr  input  64  write byte address.
- s2m_aw_valid  input  1  AW valid.
- s2m_aw_id  input  4  write ID.
- s2m_aw_prot  input  3  ignored.
- s2m_aw_ready  output  1  AW ready.
- s2m_wdata  input  64  write data.
- s2m_wvalid  input  1  W valid.
- s2m_wstrb  input  9  byte strobes; bit i enables wdata[8i+7:8i]; bit 8 ignored.
- s2m_wready  output  1  W ready.
- s2m_bvalid / s2m_bid / s2m_bresp  output  1/4/2  write response.
- s2m_bready  input  1  B ready.
- s2m_ar_addr  input  64  read byte address.
- s2m_ar_valid  input  1  AR valid.
- s2m_ar_id  input  4  read ID.
- s2m_ar_prot  input  3  ignored.
- s2m_ar_ready  output  1  AR ready.
- s2m_rdata / s2m_rvalid / s2m_rid / s2m_rrsesp  output  64/1/4/2  read response.
- s2m_rready  input  1  R ready.

## Operation
- Decode: word index = addr[IDX_W+2:3]; addr[2:0] ignored. In range iff addr[63:IDX_W+3] == 0. Otherwise resp = 2'b10 (SLVERR). In range resp = 2'b00 (OKAY).
- Write path: AW holder and W holder, one entry each, filled independently in either order.
  - s2m_aw_ready = !aw_held.
  - s2m_wready = !w_held.
  - Commit when aw_held && w_held && (!s2m_bvalid || s2m_bready).
  - Commit, in range: mem[idx] bytes updated per wstrb[7:0].
  - Commit, out of range: memory untouched.
  - On commit: bvalid=1, bid=held AW id, bresp=decode; both holders cleared.
- B: bvalid clears on bvalid && bready unless a new commit occurs on the same edge; a commit on that edge reloads it.
- Read path: s2m_ar_ready = !s2m_rvalid || s2m_rready (combinational).
  - On AR handshake: rvalid=1, rid=ar_id.
  - In range: rdata=mem[idx], rresp=OKAY.
  - Out of range: rdata=0, rresp=SLVERR.
  - R outputs hold stable while rvalid && !rready.
- Read and write paths are independent; no ordering between them.

## Timing
- Reset: all outputs driven low while arst is high. The cycle after arst deasserts: aw_ready=1, wready=1, ar_ready=1; bvalid=0, rvalid=0; bid/rid/bresp/rrsesp/rdata = 0. All mem words = 0; holders empty.
- Reset mid-transaction drops held AW/W and pending B/R with no response, and clears memory.
- Write latency: commit on the edge after the later of the AW/W handshakes; bvalid visible the cycle after that edge.
  - Case 1: AW and W handshake together on edge T: bvalid high after edge T+1.
  - Case 2: AW at T, W at T+3: bvalid high after edge T+4.
- Write throughput: one write per 2 cycles with bready held high.
- Backpressure: with bvalid=1 and bready=0, a complete AW+W pair stalls in the holders and aw_ready=wready=0 until B drains. Commit occurs on the same edge as the B handshake.
- Read latency: the AR handshake on edge T sets rvalid after T. Full throughput, one read per cycle with rready=1.
- Same-edge hazard: a read whose AR handshake coincides with a commit to the same word returns pre-write data. A read handshaken on a later edge returns the new data.
- IDs are echoed unchanged; no ID-based reordering.

## Test plan
- Reset then basic write: AW addr 0x18 id 3 with W data 0x1122334455667788, wstrb 0x0FF, same cycle. Required: bvalid 2 cycles later with bid=3, bresp=0. Then AR addr 0x18 id 5 returns rdata 0x1122334455667788, rid=5, rresp=0, one cycle after the handshake.
- Partial strobe: word 3 holds 0x1122334455667788; write 0xAAAAAAAAAAAAAAAA with wstrb 0x10F. Required readback 0x11223344AAAAAAAA (bit 8 ignored).
- Decoupled order: W at cycle 2, AW (addr 0x8) at cycle 6. Required: wready=0 cycles 3-6, bvalid after cycle 7, data written to word 1.
- Out of range, DEPTH=16: write to addr 0x80. Required: bresp=2, memory unchanged. Read of 0x80 returns rdata 0, rrsesp=2.
- Backpressure: hold bready=0 with bvalid up and issue a second write. Required: aw_ready/wready low and second B absent. Raise bready: second B follows on the next cycle with its own bid. Back-to-back ARs with rready toggling: no R beat lost or duplicated, rid order preserved.
- Hazard and reset: same-edge AR and commit to word 2 (old 0x5, new 0x9) returns 0x5; the next read returns 0x9. Assert arst with a held AW. Required: no B issued and word 2 reads 0 after reset.
